// File: rtl/cg_rvarch_sv39_tlb.sv
// Fully-associative Sv39 TLB at 4 KiB granularity, in front of the page-table walker.
// Hits answer one cycle after acceptance; misses pulse a walk request and install the result.
module cg_rvarch_sv39_tlb #(
  parameter int VADDR_WIDTH = 39,
  parameter int PADDR_WIDTH = 56,
  parameter int ATTR_WIDTH  = 11,
  parameter int ENTRIES     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_sfence,
  input  logic                   i_req_valid,
  input  logic [VADDR_WIDTH-1:0] i_req_vaddr,
  output logic                   o_req_ready,
  output logic                   o_resp_valid,
  output logic [PADDR_WIDTH-1:0] o_resp_paddr,
  output logic [ATTR_WIDTH-1:0]  o_resp_attr,
  output logic                   o_resp_fault,
  output logic                   o_tlb_miss,
  output logic [VADDR_WIDTH-1:0] o_tlb_miss_vaddr,
  input  logic                   i_ptw_valid,
  input  logic [PADDR_WIDTH-1:0] i_ptw_paddr,
  input  logic [ATTR_WIDTH-1:0]  i_ptw_pte_attr,
  input  logic                   i_ptw_fault
);

  localparam int VPN_W = VADDR_WIDTH - 12;
  localparam int PPN_W = PADDR_WIDTH - 12;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [0:0] {ST_IDLE, ST_WALK} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ENTRIES-1:0]       r_valid;
  logic [VPN_W-1:0]         r_tag  [ENTRIES];
  logic [PPN_W-1:0]         r_ppn  [ENTRIES];
  logic [ATTR_WIDTH-1:0]    r_attr [ENTRIES];
  logic [IDX_W-1:0]         r_victim_ptr;
  logic [VADDR_WIDTH-1:0]   r_walk_vaddr;
  logic                     r_sfence_seen;
  logic                     r_resp_valid;
  logic [PADDR_WIDTH-1:0]   r_resp_paddr;
  logic [ATTR_WIDTH-1:0]    r_resp_attr;
  logic                     r_resp_fault;
  logic                     r_tlb_miss;

  logic                     w_accept;
  logic                     w_hit;
  logic [PPN_W-1:0]         w_hit_ppn;
  logic [ATTR_WIDTH-1:0]    w_hit_attr;
  logic                     w_has_free;
  logic [IDX_W-1:0]         w_free_idx;
  logic [IDX_W-1:0]         w_victim;
  logic                     w_walk_done;
  logic                     w_install;
  logic [VPN_W-1:0]         w_req_vpn;

  // Handshake: a request transfers on any cycle where i_req_valid && o_req_ready;
  // responses are never back-pressured.
  assign o_req_ready = (r_state == ST_IDLE) && !i_sfence;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_req_vpn   = i_req_vaddr[VADDR_WIDTH-1:12];

  // At most one entry can match, so OR-merging the matched data selects it.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_ppn  = '0;
    w_hit_attr = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == w_req_vpn)) begin
        w_hit      = 1'b1;
        w_hit_ppn  = w_hit_ppn | r_ppn[i];
        w_hit_attr = w_hit_attr | r_attr[i];
      end
    end
  end

  // Descending scan so the lowest-index free entry is the one kept.
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_victim    = w_has_free ? w_free_idx : r_victim_ptr;
  assign w_walk_done = (r_state == ST_WALK) && (i_ptw_valid || i_ptw_fault);
  assign w_install   = (r_state == ST_WALK) && i_ptw_valid && !i_ptw_fault
                       && !i_sfence && !r_sfence_seen;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_hit) w_state_nxt = ST_WALK;
      ST_WALK: if (w_walk_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state       <= ST_IDLE;
      r_valid       <= '0;
      r_victim_ptr  <= '0;
      r_walk_vaddr  <= '0;
      r_sfence_seen <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_paddr  <= '0;
      r_resp_attr   <= '0;
      r_resp_fault  <= 1'b0;
      r_tlb_miss    <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]  <= '0;
        r_ppn[i]  <= '0;
        r_attr[i] <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_tlb_miss   <= 1'b0;

      if (w_accept && w_hit) begin
        r_resp_valid <= 1'b1;
        r_resp_paddr <= {w_hit_ppn, i_req_vaddr[11:0]};
        r_resp_attr  <= w_hit_attr;
      end

      if (w_accept && !w_hit) begin
        r_tlb_miss    <= 1'b1;
        r_walk_vaddr  <= i_req_vaddr;
        r_sfence_seen <= 1'b0;
      end

      // Any flush during the walk makes its result stale for caching.
      if ((r_state == ST_WALK) && i_sfence) r_sfence_seen <= 1'b1;

      if (w_walk_done) begin
        r_resp_valid <= 1'b1;
        if (i_ptw_fault) begin
          r_resp_fault <= 1'b1;
          r_resp_paddr <= '0;
          r_resp_attr  <= '0;
        end else begin
          r_resp_paddr <= i_ptw_paddr;
          r_resp_attr  <= i_ptw_pte_attr;
        end
      end

      if (w_install) begin
        r_valid[w_victim] <= 1'b1;
        r_tag[w_victim]   <= r_walk_vaddr[VADDR_WIDTH-1:12];
        r_ppn[w_victim]   <= i_ptw_paddr[PADDR_WIDTH-1:12];
        r_attr[w_victim]  <= i_ptw_pte_attr;
        if (!w_has_free) r_victim_ptr <= r_victim_ptr + 1'b1;
      end

      if (i_sfence) r_valid <= '0;
    end
  end

  assign o_resp_valid     = r_resp_valid;
  assign o_resp_paddr     = r_resp_paddr;
  assign o_resp_attr      = r_resp_attr;
  assign o_resp_fault     = r_resp_fault;
  assign o_tlb_miss       = r_tlb_miss;
  assign o_tlb_miss_vaddr = r_walk_vaddr;

endmodule

// File: tb/tb_cg_rvarch_sv39_tlb.sv
// Directed bench for cg_rvarch_sv39_tlb: misses, hits, eviction, faults, sfence, reset.
module tb_cg_rvarch_sv39_tlb;

  logic        clk;
  logic        i_rstn;
  logic        i_sfence;
  logic        i_req_valid;
  logic [38:0] i_req_vaddr;
  logic        o_req_ready;
  logic        o_resp_valid;
  logic [55:0] o_resp_paddr;
  logic [10:0] o_resp_attr;
  logic        o_resp_fault;
  logic        o_tlb_miss;
  logic [38:0] o_tlb_miss_vaddr;
  logic        i_ptw_valid;
  logic [55:0] i_ptw_paddr;
  logic [10:0] i_ptw_pte_attr;
  logic        i_ptw_fault;

  int checks = 0;
  int errors = 0;

  cg_rvarch_sv39_tlb dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_sfence(i_sfence),
    .i_req_valid(i_req_valid), .i_req_vaddr(i_req_vaddr), .o_req_ready(o_req_ready),
    .o_resp_valid(o_resp_valid), .o_resp_paddr(o_resp_paddr), .o_resp_attr(o_resp_attr),
    .o_resp_fault(o_resp_fault), .o_tlb_miss(o_tlb_miss), .o_tlb_miss_vaddr(o_tlb_miss_vaddr),
    .i_ptw_valid(i_ptw_valid), .i_ptw_paddr(i_ptw_paddr), .i_ptw_pte_attr(i_ptw_pte_attr),
    .i_ptw_fault(i_ptw_fault)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rstn = 1'b0;
    repeat (2) tick();
    i_rstn = 1'b1;
  endtask

  function automatic logic [38:0] fill_va(input int i);
    return 39'h12_3400_0010 + (39'(i) << 12);
  endfunction

  function automatic logic [55:0] fill_pa(input int i);
    return 56'h9000_0010 + (56'(i) << 12);
  endfunction

  // Driver: one request; on a miss the PTW model answers 3 cycles after the miss pulse.
  task automatic walk_txn(input logic [38:0] va, input logic [55:0] pa, input logic [10:0] at,
                          input logic flt, output logic miss, output logic rv,
                          output logic [55:0] rp, output logic [10:0] ra, output logic rf);
    i_req_valid = 1'b1;
    i_req_vaddr = va;
    tick();
    i_req_valid = 1'b0;
    miss = o_tlb_miss;
    rv = o_resp_valid;
    rp = o_resp_paddr;
    ra = o_resp_attr;
    rf = o_resp_fault;
    if (!o_resp_valid) begin
      repeat (2) tick();
      i_ptw_valid    = 1'b1;
      i_ptw_fault    = flt;
      i_ptw_paddr    = pa;
      i_ptw_pte_attr = at;
      tick();
      i_ptw_valid = 1'b0;
      i_ptw_fault = 1'b0;
      rv = o_resp_valid;
      rp = o_resp_paddr;
      ra = o_resp_attr;
      rf = o_resp_fault;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({o_req_ready, o_resp_valid, o_resp_fault, o_tlb_miss} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 1000", {o_req_ready, o_resp_valid, o_resp_fault, o_tlb_miss});
    end
    checks++;
    if ({o_resp_paddr, o_resp_attr, o_tlb_miss_vaddr} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h exp 0", o_resp_paddr, o_resp_attr, o_tlb_miss_vaddr);
    end
  endtask

  task automatic test_cold_miss_and_rehit();
    int miss_pulses;
    logic m, rv, rf;
    logic [55:0] rp;
    logic [10:0] ra;
    apply_reset();
    i_req_valid = 1'b1;
    i_req_vaddr = 39'h40_0000_1234;
    tick();
    i_req_valid = 1'b0;
    miss_pulses = int'(o_tlb_miss);
    checks++;
    if (o_tlb_miss_vaddr !== 39'h40_0000_1234) begin
      errors++;
      $display("FAIL miss_vaddr got %h exp 4000001234", o_tlb_miss_vaddr);
    end
    checks++;
    if ({o_req_ready, o_resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL walk_busy got %b exp 00", {o_req_ready, o_resp_valid});
    end
    repeat (4) begin
      tick();
      miss_pulses += int'(o_tlb_miss);
    end
    checks++;
    if (o_tlb_miss_vaddr !== 39'h40_0000_1234) begin
      errors++;
      $display("FAIL miss_vaddr_hold got %h exp 4000001234", o_tlb_miss_vaddr);
    end
    i_ptw_valid = 1'b1;
    i_ptw_paddr = 56'h8000_1234;
    i_ptw_pte_attr = 11'h0CF;
    tick();
    i_ptw_valid = 1'b0;
    miss_pulses += int'(o_tlb_miss);
    checks++;
    if (miss_pulses !== 1) begin
      errors++;
      $display("FAIL miss_pulses got %0d exp 1", miss_pulses);
    end
    checks++;
    if ({o_resp_valid, o_resp_fault, o_resp_paddr, o_resp_attr} !== {1'b1, 1'b0, 56'h8000_1234, 11'h0CF}) begin
      errors++;
      $display("FAIL cold_resp got v%b f%b %h %h exp v1 f0 80001234 0cf",
               o_resp_valid, o_resp_fault, o_resp_paddr, o_resp_attr);
    end
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_walk got %b exp 1", o_req_ready);
    end
    walk_txn(39'h40_0000_1FF8, 56'h0, 11'h0, 1'b0, m, rv, rp, ra, rf);
    checks++;
    if ({m, rv, rf, rp, ra} !== {1'b0, 1'b1, 1'b0, 56'h8000_1FF8, 11'h0CF}) begin
      errors++;
      $display("FAIL rehit got m%b v%b f%b %h %h exp m0 v1 f0 80001ff8 0cf", m, rv, rf, rp, ra);
    end
    tick();
    checks++;
    if (o_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_pulse got %b exp 0", o_resp_valid);
    end
  endtask

  task automatic test_fill_evict_back_to_back();
    int misses, good_hits;
    logic m, rv, rf;
    logic [55:0] rp;
    logic [10:0] ra;
    apply_reset();
    misses = 0;
    for (int i = 0; i < 9; i++) begin
      walk_txn(fill_va(i), fill_pa(i), 11'h0C7, 1'b0, m, rv, rp, ra, rf);
      misses += int'(m);
    end
    checks++;
    if (misses !== 9) begin
      errors++;
      $display("FAIL fill_misses got %0d exp 9", misses);
    end
    good_hits = 0;
    for (int i = 1; i < 9; i++) begin
      walk_txn(fill_va(i), 56'h0, 11'h0, 1'b0, m, rv, rp, ra, rf);
      if (!m && rv && rp == fill_pa(i) && ra == 11'h0C7) good_hits++;
    end
    checks++;
    if (good_hits !== 8) begin
      errors++;
      $display("FAIL pages1to8_hit got %0d exp 8", good_hits);
    end
    i_req_valid = 1'b1;
    i_req_vaddr = fill_va(2);
    tick();
    checks++;
    if ({o_resp_valid, o_resp_paddr} !== {1'b1, fill_pa(2)}) begin
      errors++;
      $display("FAIL b2b_first got v%b %h exp v1 %h", o_resp_valid, o_resp_paddr, fill_pa(2));
    end
    i_req_vaddr = fill_va(3) + 39'h100;
    tick();
    i_req_valid = 1'b0;
    checks++;
    if ({o_resp_valid, o_tlb_miss, o_resp_paddr} !== {1'b1, 1'b0, fill_pa(3) + 56'h100}) begin
      errors++;
      $display("FAIL b2b_second got v%b m%b %h exp v1 m0 %h", o_resp_valid, o_tlb_miss,
               o_resp_paddr, fill_pa(3) + 56'h100);
    end
    walk_txn(fill_va(0), fill_pa(0), 11'h0C7, 1'b0, m, rv, rp, ra, rf);
    checks++;
    if ({m, rv, rp} !== {1'b1, 1'b1, fill_pa(0)}) begin
      errors++;
      $display("FAIL page0_evicted got m%b v%b %h exp m1 v1 %h", m, rv, rp, fill_pa(0));
    end
  endtask

  task automatic test_ptw_fault();
    logic m, rv, rf;
    logic [55:0] rp;
    logic [10:0] ra;
    apply_reset();
    walk_txn(39'h1000, 56'h7777_7000, 11'h0CF, 1'b1, m, rv, rp, ra, rf);
    checks++;
    if ({m, rv, rf} !== 3'b111) begin
      errors++;
      $display("FAIL fault_resp got m%b v%b f%b exp 111", m, rv, rf);
    end
    walk_txn(39'h1000, 56'h5555_5000, 11'h0CF, 1'b0, m, rv, rp, ra, rf);
    checks++;
    if ({m, rv, rf, rp} !== {3'b110, 56'h5555_5000}) begin
      errors++;
      $display("FAIL fault_retry got m%b v%b f%b %h exp 110 55555000", m, rv, rf, rp);
    end
  endtask

  task automatic test_sfence();
    logic m, rv, rf;
    logic [55:0] rp;
    logic [10:0] ra;
    apply_reset();
    walk_txn(39'h3000, 56'hA000_3000, 11'h0CF, 1'b0, m, rv, rp, ra, rf);
    i_sfence = 1'b1;
    #1;
    checks++;
    if (o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_sfence got %b exp 0", o_req_ready);
    end
    i_sfence = 1'b0;
    walk_txn(39'h3000, 56'hA000_3000, 11'h0CF, 1'b0, m, rv, rp, ra, rf);
    i_req_valid = 1'b1;
    i_req_vaddr = 39'h5000;
    tick();
    i_req_valid = 1'b0;
    tick();
    i_sfence = 1'b1;
    tick();
    i_sfence = 1'b0;
    tick();
    i_ptw_valid = 1'b1;
    i_ptw_paddr = 56'hB000_5000;
    i_ptw_pte_attr = 11'h0C3;
    tick();
    i_ptw_valid = 1'b0;
    checks++;
    if ({o_resp_valid, o_resp_fault, o_resp_paddr} !== {2'b10, 56'hB000_5000}) begin
      errors++;
      $display("FAIL sfence_walk_resp got v%b f%b %h exp v1 f0 b0005000", o_resp_valid, o_resp_fault, o_resp_paddr);
    end
    walk_txn(39'h5000, 56'hB000_5000, 11'h0C3, 1'b0, m, rv, rp, ra, rf);
    checks++;
    if (m !== 1'b1) begin
      errors++;
      $display("FAIL sfence_no_install got miss %b exp 1", m);
    end
    walk_txn(39'h3000, 56'hA000_3000, 11'h0CF, 1'b0, m, rv, rp, ra, rf);
    checks++;
    if (m !== 1'b1) begin
      errors++;
      $display("FAIL sfence_flushed_prior got miss %b exp 1", m);
    end
    i_req_valid = 1'b1;
    i_req_vaddr = 39'h7000;
    tick();
    i_req_valid = 1'b0;
    repeat (2) tick();
    i_ptw_valid = 1'b1;
    i_sfence = 1'b1;
    i_ptw_paddr = 56'hC000_7000;
    tick();
    i_ptw_valid = 1'b0;
    i_sfence = 1'b0;
    walk_txn(39'h7000, 56'hC000_7000, 11'h0CF, 1'b0, m, rv, rp, ra, rf);
    checks++;
    if (m !== 1'b1) begin
      errors++;
      $display("FAIL sfence_wins_install got miss %b exp 1", m);
    end
  endtask

  task automatic test_reset_mid_walk();
    logic m, rv, rf;
    logic [55:0] rp;
    logic [10:0] ra;
    apply_reset();
    walk_txn(39'h9000, 56'hD000_9000, 11'h0CF, 1'b0, m, rv, rp, ra, rf);
    i_req_valid = 1'b1;
    i_req_vaddr = 39'hB000;
    tick();
    i_req_valid = 1'b0;
    tick();
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
    checks++;
    if ({o_req_ready, o_resp_valid, o_resp_fault, o_tlb_miss} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_walk_ctrl got %b exp 1000", {o_req_ready, o_resp_valid, o_resp_fault, o_tlb_miss});
    end
    checks++;
    if ({o_resp_paddr, o_resp_attr, o_tlb_miss_vaddr} !== '0) begin
      errors++;
      $display("FAIL rst_walk_data got %h/%h/%h exp 0", o_resp_paddr, o_resp_attr, o_tlb_miss_vaddr);
    end
    walk_txn(39'h9000, 56'hD000_9000, 11'h0CF, 1'b0, m, rv, rp, ra, rf);
    checks++;
    if (m !== 1'b1) begin
      errors++;
      $display("FAIL rst_flushed_entry got miss %b exp 1", m);
    end
  endtask

  initial begin
    i_rstn = 1'b0;
    i_sfence = 1'b0;
    i_req_valid = 1'b0;
    i_req_vaddr = '0;
    i_ptw_valid = 1'b0;
    i_ptw_paddr = '0;
    i_ptw_pte_attr = '0;
    i_ptw_fault = 1'b0;
    test_reset();
    test_cold_miss_and_rehit();
    test_fill_evict_back_to_back();
    test_ptw_fault();
    test_sfence();
    test_reset_mid_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
